// File: rtl/alu_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_stage_pkg
// Description : Opcode encodings and flag-bit positions shared by the ALU stage.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_stage_pkg;

    localparam logic [3:0] OP_PASS_A = 4'h0;
    localparam logic [3:0] OP_PASS_B = 4'h1;
    localparam logic [3:0] OP_NOT_A  = 4'h2;
    localparam logic [3:0] OP_NOT_B  = 4'h3;
    localparam logic [3:0] OP_ADD    = 4'h4;
    localparam logic [3:0] OP_ADC    = 4'h5;
    localparam logic [3:0] OP_SUB    = 4'h6;
    localparam logic [3:0] OP_AND    = 4'h7;
    localparam logic [3:0] OP_OR     = 4'h8;
    localparam logic [3:0] OP_XOR    = 4'h9;
    localparam logic [3:0] OP_LSL    = 4'hA;
    localparam logic [3:0] OP_LSR    = 4'hB;
    localparam logic [3:0] OP_ASL    = 4'hC;
    localparam logic [3:0] OP_ASR    = 4'hD;
    localparam logic [3:0] OP_CSL    = 4'hE;
    localparam logic [3:0] OP_CSR    = 4'hF;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

endpackage
`default_nettype wire

// File: rtl/alu_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_stage_if
// Description : Operand/opcode request and registered result bundle of the ALU stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_stage_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       FunSel;
    logic             InValid;
    logic             WF;
    logic [WIDTH-1:0] OutALU;
    logic             OutValid;
    logic [3:0]       Flags;

    modport master (
        output A, B, FunSel, InValid, WF,
        input  OutALU, OutValid, Flags
    );

    modport slave (
        input  A, B, FunSel, InValid, WF,
        output OutALU, OutValid, Flags
    );
endinterface
`default_nettype wire

// File: rtl/alu_stage_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Combinational ALU: result and next flag value {Z,C,N,O}.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_stage_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       fun_sel,
    input  logic [3:0]       flags_in,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags_out
);

    localparam int MSB = WIDTH - 1;

    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] nb;

    assign cin = flags_in[FLAG_C];
    assign nb  = ~b;

    always_comb begin
        sum       = '0;
        result    = '0;
        flags_out = flags_in;
        case (fun_sel)
            OP_PASS_A: result = a;
            OP_PASS_B: result = b;
            OP_NOT_A:  result = ~a;
            OP_NOT_B:  result = ~b;
            OP_ADD, OP_ADC: begin
                sum    = {1'b0, a} + {1'b0, b} +
                         {{WIDTH{1'b0}}, (fun_sel == OP_ADC) ? cin : 1'b0};
                result = sum[WIDTH-1:0];
                flags_out[FLAG_C] = sum[WIDTH];
                flags_out[FLAG_O] = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                // Carry out of A + ~B + 1 reads as "no borrow".
                sum    = {1'b0, a} + {1'b0, nb} + {{WIDTH{1'b0}}, 1'b1};
                result = sum[WIDTH-1:0];
                flags_out[FLAG_C] = sum[WIDTH];
                flags_out[FLAG_O] = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_LSL: begin
                result = {a[MSB-1:0], 1'b0};
                flags_out[FLAG_C] = a[MSB];
            end
            OP_LSR: begin
                result = {1'b0, a[MSB:1]};
                flags_out[FLAG_C] = a[0];
            end
            OP_ASL: begin
                result = {a[MSB-1:0], 1'b0};
                flags_out[FLAG_C] = a[MSB];
                flags_out[FLAG_O] = a[MSB] ^ a[MSB-1];
            end
            OP_ASR: begin
                result = {a[MSB], a[MSB:1]};
                flags_out[FLAG_C] = a[0];
            end
            OP_CSL: begin
                result = {a[MSB-1:0], cin};
                flags_out[FLAG_C] = a[MSB];
            end
            OP_CSR: begin
                result = {cin, a[MSB:1]};
                flags_out[FLAG_C] = a[0];
            end
            default: result = '0;
        endcase
        flags_out[FLAG_Z] = (result == '0);
        flags_out[FLAG_N] = result[MSB];
    end

endmodule
`default_nettype wire

// File: rtl/alu_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_stage
// Description : One-cycle registered ALU stage with result, valid and flag registers.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_stage
    import alu_stage_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    alu_stage_if.slave  bus
);

    logic [WIDTH-1:0] result;
    logic [3:0]       flags_next;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a         (bus.A),
        .b         (bus.B),
        .fun_sel   (bus.FunSel),
        .flags_in  (bus.Flags),
        .result    (result),
        .flags_out (flags_next)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            bus.OutALU   <= '0;
            bus.OutValid <= 1'b0;
            bus.Flags    <= 4'b0000;
        end else begin
            bus.OutValid <= bus.InValid;
            if (bus.InValid) begin
                bus.OutALU <= result;
                if (bus.WF) begin
                    bus.Flags <= flags_next;
                end
            end
        end
    end

endmodule
`default_nettype wire
